cordic_rotator: RTL

CORDIC_ROTATOR -- requirements
Module: cordic_rotator

---
 rtl/cordic_rotator.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cordic_rotator.sv
// Iterative CORDIC rotator: one micro-rotation per cycle, with the direction supplied externally via d/dn.
// Optional macro CORDIC_ROTATOR_ROUND_EN rounds each shifted term half-up instead of truncating it.
module cordic_rotator #(
  parameter int W      = 16,
  parameter int N_ITER = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  input  logic [W-1:0] z_in,
  input  logic         d,
  input  logic         dn,
  output logic [3:0]   iter,
  output logic [W-1:0] x_out,
  output logic [W-1:0] y_out,
  output logic [W-1:0] z_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         dir_err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int ASH = (W >= 16) ? W - 16 : 0;
  localparam int RSH = (W < 16) ? 16 - W : 0;

  state_t         state_q, state_d;
  logic [W-1:0]   x_q, x_d, y_q, y_d, z_q, z_d;
  logic [3:0]     iter_q, iter_d;
  logic           dir_err_q, dir_err_d;
  logic [W-1:0]   x_sh, y_sh, atan_v;

  // The angle table is defined at 16-bit scaling and rescaled to the datapath width.
  function automatic logic [W-1:0] atan_at(input logic [3:0] i);
    int a;
    case (i)
      4'd0:    a = 8192;
      4'd1:    a = 4836;
      4'd2:    a = 2555;
      4'd3:    a = 1297;
      4'd4:    a = 651;
      4'd5:    a = 326;
      4'd6:    a = 163;
      4'd7:    a = 81;
      4'd8:    a = 41;
      4'd9:    a = 20;
      4'd10:   a = 10;
      4'd11:   a = 5;
      default: a = 0;
    endcase
    return W'((longint'(a) << ASH) >> RSH);
  endfunction

  function automatic logic [W-1:0] sh_term(input logic [W-1:0] v, input logic [3:0] s);
    logic [W-1:0] t;
`ifdef CORDIC_ROTATOR_ROUND_EN
    logic [W-1:0] r;
`endif
    t = $signed(v) >>> s;
`ifdef CORDIC_ROTATOR_ROUND_EN
    if (s != 4'd0) begin
      r = $signed(v) >>> (s - 4'd1);
      t = t + (r & {{(W-1){1'b0}}, 1'b1});
    end
`endif
    return t;
  endfunction

  assign x_sh   = sh_term(x_q, iter_q);
  assign y_sh   = sh_term(y_q, iter_q);
  assign atan_v = atan_at(iter_q);

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    iter_d    = iter_q;
    dir_err_d = dir_err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d       = x_in;
          y_d       = y_in;
          z_d       = z_in;
          iter_d    = 4'd0;
          dir_err_d = 1'b0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (d != dn) begin
          if (d) begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_v;
          end else begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_v;
          end
          iter_d = iter_q + 4'd1;
          if (iter_q == 4'(N_ITER - 1)) state_d = DONE;
        end else if (d) begin
          dir_err_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          iter_d  = 4'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      iter_q    <= 4'd0;
      dir_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      iter_q    <= iter_d;
      dir_err_q <= dir_err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign iter      = iter_q;
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign z_out     = z_q;
  assign dir_err   = dir_err_q;

endmodule
